// File: rtl/store_write_buffer.sv
// Store write buffer: formats committed MIPS stores (sw/sb/sh/swl/swr) into
// word address, byte strobes and lane data, then drains them in FIFO order to the DCache.
// Optional load-hazard compare is enabled with `define SB_LOAD_HAZARD_EN.
module store_write_buffer #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [4:0]    st_op,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_rt,
    input  logic          st_ex,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [31:0]   wb_addr,
    output logic [3:0]    wb_wstrb,
    output logic [31:0]   wb_wdata,
    output logic [AW:0]   sb_count,
    output logic          sb_empty,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high. Ready never depends on valid, and the wb_* payload is held stable while
    // wb_valid is high and wb_ready is low.

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [29:0]   addr_mem [DEPTH];
    logic [3:0]    strb_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [3:0]    fmt_strb;
    logic [31:0]   fmt_data;
    logic          push;
    logic          pop;

    assign st_ready = (count != FULL);
    assign wb_valid = (count != '0);
    assign sb_empty = (count == '0);
    assign sb_count = count;

    // Excepting or empty-op stores complete the handshake but are never stored.
    assign push = st_valid && st_ready && !st_ex && (|st_op);
    assign pop  = wb_valid && wb_ready;

    always_comb begin
        fmt_strb = 4'b0000;
        fmt_data = st_rt;
        if (st_op[0]) begin
            fmt_strb = 4'b1111;
            fmt_data = st_rt;
        end else if (st_op[1]) begin
            fmt_strb = 4'b0001 << st_addr[1:0];
            fmt_data = {4{st_rt[7:0]}};
        end else if (st_op[2]) begin
            fmt_strb = st_addr[1] ? 4'b1100 : 4'b0011;
            fmt_data = {2{st_rt[15:0]}};
        end else if (st_op[3]) begin
            // swl writes the high-order bytes of rt into the low lanes up to a.
            case (st_addr[1:0])
                2'd0:    begin fmt_strb = 4'b0001; fmt_data = {24'b0, st_rt[31:24]}; end
                2'd1:    begin fmt_strb = 4'b0011; fmt_data = {16'b0, st_rt[31:16]}; end
                2'd2:    begin fmt_strb = 4'b0111; fmt_data = {8'b0,  st_rt[31:8]};  end
                default: begin fmt_strb = 4'b1111; fmt_data = st_rt;                 end
            endcase
        end else if (st_op[4]) begin
            case (st_addr[1:0])
                2'd0:    begin fmt_strb = 4'b1111; fmt_data = st_rt;                 end
                2'd1:    begin fmt_strb = 4'b1110; fmt_data = {st_rt[23:0], 8'b0};  end
                2'd2:    begin fmt_strb = 4'b1100; fmt_data = {st_rt[15:0], 16'b0}; end
                default: begin fmt_strb = 4'b1000; fmt_data = {st_rt[7:0], 24'b0};  end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            strb_mem[wr_ptr] <= fmt_strb;
            data_mem[wr_ptr] <= fmt_data;
        end
    end

    assign wb_addr  = {addr_mem[rd_ptr], 2'b00};
    assign wb_wstrb = strb_mem[rd_ptr];
    assign wb_wdata = data_mem[rd_ptr];

`ifdef SB_LOAD_HAZARD_EN
    logic          hazard_hit;
    logic [AW-1:0] offs;

    // An entry is live when its distance from rd_ptr is below the occupancy.
    always_comb begin
        offs       = '0;
        hazard_hit = push && (st_addr[31:2] == ld_addr[31:2]);
        for (int i = 0; i < DEPTH; i++) begin
            offs = AW'(i) - rd_ptr;
            if (({1'b0, offs} < count) && (addr_mem[i] == ld_addr[31:2]))
                hazard_hit = 1'b1;
        end
    end

    assign ld_hazard = ld_valid && hazard_hit;
`else
    logic unused_ld;
    assign unused_ld = &{1'b0, ld_valid, ld_addr};
    assign ld_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed stores, scoreboard queue checked by a
// negedge monitor on every wb handshake, plus occupancy, hazard and reset checks.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    localparam logic [4:0] OP_SW  = 5'b00001;
    localparam logic [4:0] OP_SB  = 5'b00010;
    localparam logic [4:0] OP_SH  = 5'b00100;
    localparam logic [4:0] OP_SWL = 5'b01000;
    localparam logic [4:0] OP_SWR = 5'b10000;

    logic        clk;
    logic        resetn;
    logic        st_valid;
    logic        st_ready;
    logic [4:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_rt;
    logic        st_ex;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_addr;
    logic [3:0]  wb_wstrb;
    logic [31:0] wb_wdata;
    logic [AW:0] sb_count;
    logic        sb_empty;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;

    logic [67:0] exp_q[$];
    int          n_checks;
    int          n_passed;

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_rt     (st_rt),
        .st_ex     (st_ex),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_wstrb  (wb_wstrb),
        .wb_wdata  (wb_wdata),
        .sb_count  (sb_count),
        .sb_empty  (sb_empty),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // scoreboard monitor: every accepted head is compared against the queue
    always @(negedge clk) begin
        if (resetn && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected_pop", {wb_addr, wb_wstrb, wb_wdata}, 68'h0);
            end else begin
                check("wb_head", {wb_addr, wb_wstrb, wb_wdata}, exp_q.pop_front());
            end
        end
    end

    // driver: starts and ends at posedge+1; expected entry queued at the transfer
    task automatic push_store(input logic [4:0] op, input logic [31:0] addr,
                              input logic [31:0] rt, input logic ex,
                              input logic [3:0] e_strb, input logic [31:0] e_data);
        bit done;
        done     = 1'b0;
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_rt    = rt;
        st_ex    = ex;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (st_ready) done = 1'b1;
        end
        if (!done) check("st_ready_timeout", 68'h0, 68'h1);
        else if (!ex) exp_q.push_back({addr[31:2], 2'b00, e_strb, e_data});
        @(posedge clk); #1;
        st_valid = 1'b0;
        st_ex    = 1'b0;
        st_op    = 5'b0;
    endtask

    task automatic drain();
        bit done;
        done     = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (sb_empty) done = 1'b1;
        end
        if (!done) check("drain_timeout", 68'h0, 68'h1);
        @(posedge clk); #1;
        wb_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        resetn   = 1'b0;
        st_valid = 1'b0;
        st_op    = 5'b0;
        st_addr  = 32'h0;
        st_rt    = 32'h0;
        st_ex    = 1'b0;
        wb_ready = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 68'(wb_valid), 68'h0);
        check("rst_st_ready", 68'(st_ready), 68'h1);
        check("rst_sb_empty", 68'(sb_empty), 68'h1);
        check("rst_sb_count", 68'(sb_count), 68'h0);
        check("rst_ld_hazard", 68'(ld_hazard), 68'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1: sb with one-cycle latency to the head
        push_store(OP_SB, 32'h0000_1003, 32'h1234_5678, 1'b0, 4'b1000, 32'h7878_7878);
        check("sb_latency_valid", 68'(wb_valid), 68'h1);
        check("sb_head_now", {wb_addr, wb_wstrb, wb_wdata}, {32'h0000_1000, 4'b1000, 32'h7878_7878});
        drain();

        // 2: swl/swr/sh formatting
        push_store(OP_SWL, 32'h0000_2001, 32'hAABB_CCDD, 1'b0, 4'b0011, 32'h0000_AABB);
        push_store(OP_SWR, 32'h0000_2002, 32'hAABB_CCDD, 1'b0, 4'b1100, 32'hCCDD_0000);
        push_store(OP_SWL, 32'h0000_2000, 32'hAABB_CCDD, 1'b0, 4'b0001, 32'h0000_00AA);
        push_store(OP_SWR, 32'h0000_2003, 32'hAABB_CCDD, 1'b0, 4'b1000, 32'hDD00_0000);
        drain();
        push_store(OP_SH,  32'h0000_2402, 32'h1122_3344, 1'b0, 4'b1100, 32'h3344_3344);
        push_store(OP_SWL, 32'h0000_2403, 32'h1122_3344, 1'b0, 4'b1111, 32'h1122_3344);
        push_store(OP_SWR, 32'h0000_2401, 32'h1122_3344, 1'b0, 4'b1110, 32'h2233_4400);
        push_store(OP_SB,  32'h0000_2400, 32'h1122_33A5, 1'b0, 4'b0001, 32'hA5A5_A5A5);
        drain();

        // 3: fill, pulse pop, push+pop, drain in order
        push_store(OP_SW, 32'h0000_4000, 32'h0000_0001, 1'b0, 4'b1111, 32'h0000_0001);
        push_store(OP_SW, 32'h0000_4004, 32'h0000_0002, 1'b0, 4'b1111, 32'h0000_0002);
        push_store(OP_SW, 32'h0000_4008, 32'h0000_0003, 1'b0, 4'b1111, 32'h0000_0003);
        push_store(OP_SW, 32'h0000_400C, 32'h0000_0004, 1'b0, 4'b1111, 32'h0000_0004);
        @(negedge clk);
        check("full_count", 68'(sb_count), 68'd4);
        check("full_st_ready", 68'(st_ready), 68'h0);
        @(posedge clk); #1;
        wb_ready = 1'b1;
        @(posedge clk); #1;
        wb_ready = 1'b0;
        @(negedge clk);
        check("after_pop_count", 68'(sb_count), 68'd3);
        check("after_pop_st_ready", 68'(st_ready), 68'h1);
        @(posedge clk); #1;
        wb_ready = 1'b1;
        push_store(OP_SW, 32'h0000_4010, 32'h0000_0005, 1'b0, 4'b1111, 32'h0000_0005);
        wb_ready = 1'b0;
        @(negedge clk);
        check("pushpop_count", 68'(sb_count), 68'd3);
        @(posedge clk); #1;
        drain();

        // 4: excepting store is accepted and dropped
        push_store(OP_SW, 32'h0000_5000, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ex_count", 68'(sb_count), 68'h0);
        check("ex_wb_valid", 68'(wb_valid), 68'h0);
        @(posedge clk); #1;

        // 5: load hazard
        push_store(OP_SW, 32'h0000_3004, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0BAD_F00D);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3006;
        #1;
`ifdef SB_LOAD_HAZARD_EN
        check("hazard_match", 68'(ld_hazard), 68'h1);
`else
        check("hazard_tied", 68'(ld_hazard), 68'h0);
`endif
        ld_addr = 32'h0000_3008;
        #1;
        check("hazard_other_word", 68'(ld_hazard), 68'h0);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        drain();
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_3004;
        #1;
        check("hazard_after_pop", 68'(ld_hazard), 68'h0);
        ld_valid = 1'b0;
        @(posedge clk); #1;

        // 6: async reset mid-drain discards pending entries
        push_store(OP_SW, 32'h0000_6000, 32'h1, 1'b0, 4'b1111, 32'h1);
        push_store(OP_SW, 32'h0000_6004, 32'h2, 1'b0, 4'b1111, 32'h2);
        push_store(OP_SW, 32'h0000_6008, 32'h3, 1'b0, 4'b1111, 32'h3);
        @(negedge clk);
        check("pre_reset_count", 68'(sb_count), 68'd3);
        #2;
        resetn = 1'b0;
        #1;
        check("async_wb_valid", 68'(wb_valid), 68'h0);
        check("async_sb_empty", 68'(sb_empty), 68'h1);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_st_ready", 68'(st_ready), 68'h1);
        check("post_reset_count", 68'(sb_count), 68'h0);

        // buffer still works after reset
        push_store(OP_SH, 32'h0000_7000, 32'hCAFE_1234, 1'b0, 4'b0011, 32'h1234_1234);
        drain();
        check("queue_empty_end", 68'(exp_q.size()), 68'h0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
